// File: rtl/mem_stage_lsu.sv
// Load/store unit for the memory stage of a pipelined RV32I core.
// It issues one access at a time on a request/grant data bus and stalls the
// pipeline until that access completes. Sub-word stores are placed on their
// byte lanes, loaded data is extracted and extended, and misaligned,
// illegal or timed-out accesses raise a one-cycle error pulse.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RD_data,
    output logic        StallM,
    output logic        ErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    lat_lo;
    logic [2:0]    lat_f3;

    logic access, illegal, misaligned, fault, valid, timeout_hit;

    // Sign/zero-extend the addressed byte or halfword of a read word.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Classify the access presented by the M stage.
    always_comb begin
        access      = MemReadM | MemWriteM;
        illegal     = (MemReadM & MemWriteM)
                    | (MemReadM & (funct3M == 3'b011 || funct3M == 3'b110 || funct3M == 3'b111))
                    | (MemWriteM & (funct3M[2] | (funct3M[1] & funct3M[0])));
        misaligned  = (funct3M[1:0] == 2'b01 && ALUResultM[0])
                    | (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
        fault       = access & (illegal | misaligned);
        valid       = access & ~fault;
        timeout_hit = (cnt == CW'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and stall decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        StallM    = 1'b0;
        case (state)
            IDLE: begin
                StallM = valid & clr;
                if (valid) state_nxt = REQ;
            end
            REQ: begin
                StallM = 1'b1;
                if (bus_gnt)          state_nxt = bus_we ? DONE : WAIT_R;
                else if (timeout_hit) state_nxt = DONE;
            end
            WAIT_R: begin
                StallM = 1'b1;
                if (bus_rvalid || timeout_hit) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus request registers, timeout counter, error pulse and load result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            ErrM      <= 1'b0;
            RD_data   <= '0;
            cnt       <= '0;
            lat_lo    <= '0;
            lat_f3    <= '0;
        end else begin
            ErrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (fault) begin
                        ErrM    <= 1'b1;
                        RD_data <= '0;
                    end else if (valid) begin
                        bus_req  <= 1'b1;
                        bus_we   <= MemWriteM;
                        bus_addr <= {ALUResultM[31:2], 2'b00};
                        cnt      <= '0;
                        lat_lo   <= ALUResultM[1:0];
                        lat_f3   <= funct3M;
                        if (MemReadM) begin
                            bus_be    <= 4'b1111;
                            bus_wdata <= WriteDataM;
                        end else begin
                            case (funct3M[1:0])
                                2'b00: begin
                                    bus_be    <= 4'b0001 << ALUResultM[1:0];
                                    bus_wdata <= {4{WriteDataM[7:0]}};
                                end
                                2'b01: begin
                                    bus_be    <= ALUResultM[1] ? 4'b1100 : 4'b0011;
                                    bus_wdata <= {2{WriteDataM[15:0]}};
                                end
                                default: begin
                                    bus_be    <= 4'b1111;
                                    bus_wdata <= WriteDataM;
                                end
                            endcase
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        ErrM    <= 1'b1;
                        RD_data <= '0;
                    end
                end
                WAIT_R: begin
                    cnt <= cnt + 1'b1;
                    if (bus_rvalid) begin
                        RD_data <= extract(lat_f3, lat_lo, bus_rdata);
                    end else if (timeout_hit) begin
                        ErrM    <= 1'b1;
                        RD_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu: stores, loads with extension,
// fault rejection, timeout and mid-transaction reset.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        clr;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] RD_data;
    logic        StallM, ErrM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .clr(clr),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RD_data(RD_data), .StallM(StallM), .ErrM(ErrM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    // Run one valid access; grant arrives in the gnt_dly-th REQ cycle and
    // read data (loads) the cycle after the grant.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int gnt_dly,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                             input int exp_stall);
        int req_cyc, stall_cyc;
        bit ok_bus, err_seen, done, gnt_prev;
        req_cyc = 0; stall_cyc = 0; ok_bus = 1; err_seen = 0; done = 0; gnt_prev = 0;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; bus_rdata = rdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (bus_req) req_cyc++;
            bus_rvalid = gnt_prev & rd;
            bus_gnt    = bus_req && (req_cyc == gnt_dly);
            gnt_prev   = bus_gnt;
            @(negedge clk);
            if (ErrM) err_seen = 1;
            if (StallM) stall_cyc++;
            if (bus_req && (bus_addr !== {addr[31:2], 2'b00} || bus_be !== exp_be ||
                            bus_we !== wr || (wr && bus_wdata !== exp_wd)))
                ok_bus = 0;
            if (!StallM) begin
                done = 1;
                check({tag, "_rd_data"}, RD_data, exp_rd);
                check({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
            end
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_cycles"}, stall_cyc, exp_stall);
        check({tag, "_bus_fields"}, {31'd0, ok_bus}, 32'd1);
        check({tag, "_req_cycles"}, req_cyc, gnt_dly);
        check({tag, "_no_err"}, {31'd0, err_seen}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Present a faulting access; expect an error pulse and no bus activity.
    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3;
        ALUResultM = addr; WriteDataM = 32'h1234_5678;
        @(negedge clk);
        check({tag, "_stall"}, {31'd0, StallM}, 32'd0);
        check({tag, "_req0"}, {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check({tag, "_err"}, {31'd0, ErrM}, 32'd1);
        check({tag, "_req1"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_rd_zero"}, RD_data, 32'd0);
        @(negedge clk);
        check({tag, "_err_end"}, {31'd0, ErrM}, 32'd0);
        check({tag, "_req2"}, {31'd0, bus_req}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"}, RD_data, 32'd0);
        check({tag, "_ctl"}, {28'd0, StallM, ErrM, bus_req, bus_we}, 32'd0);
        check({tag, "_addr"}, bus_addr, 32'd0);
        check({tag, "_wdata"}, bus_wdata, 32'd0);
        check({tag, "_be"}, {28'd0, bus_be}, 32'd0);
    endtask

    initial begin
        int k;
        idle_inputs();
        bus_rdata = '0;
        clr = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(posedge clk);

        do_access("sw",  1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 32'h0,
                  4'b1111, 32'hDEAD_BEEF, 32'h0, 3);
        do_access("sb",  1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 1, 32'h0,
                  4'b1000, 32'hA5A5_A5A5, 32'h0, 2);
        do_access("lb",  1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h8012_3456,
                  4'b1111, 32'h0, 32'hFFFF_FF80, 3);
        do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'hBEEF_1234,
                  4'b1111, 32'h0, 32'h0000_BEEF, 3);
        do_access("lh",  1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'hBEEF_1234,
                  4'b1111, 32'h0, 32'hFFFF_BEEF, 3);
        do_access("sh",  1'b0, 1'b1, 3'b001, 32'h102, 32'h1122_5566, 1, 32'h0,
                  4'b1100, 32'h5566_5566, 32'hFFFF_BEEF, 2);
        do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 1, 32'h0000_9A00,
                  4'b1111, 32'h0, 32'h0000_009A, 3);

        do_fault("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h101);
        do_fault("ld_f3_011",   1'b1, 1'b0, 3'b011, 32'h100);
        do_fault("rd_and_wr",   1'b1, 1'b1, 3'b010, 32'h100);
        do_fault("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h102);

        // Reset in the middle of a load: outputs clear at once.
        do_access("lw_pre", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 1, 32'h1357_9BDF,
                  4'b1111, 32'h0, 32'h1357_9BDF, 3);
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h200;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #2;
        check("mid_wait_req", {31'd0, bus_req}, 32'd0);
        check("mid_wait_stall", {31'd0, StallM}, 32'd1);
        clr = 1'b0;
        #1;
        check_all_zero("async_clr");
        idle_inputs();
        @(negedge clk);
        clr = 1'b1;
        do_access("lw_after", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1, 32'hCAFE_F00D,
                  4'b1111, 32'h0, 32'hCAFE_F00D, 3);

        // Load granted but never answered: abandoned after 16 cycles.
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h300;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            bus_gnt = (k == 1);
            @(negedge clk);
            if (ErrM) break;
        end
        check("timeout_cycle", k, 17);
        check("timeout_rd", RD_data, 32'd0);
        check("timeout_stall", {31'd0, StallM}, 32'd0);
        check("timeout_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        @(negedge clk);
        check("late_rvalid_err", {31'd0, ErrM}, 32'd0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_rd", RD_data, 32'd0);
        check("late_rvalid_ctl", {30'd0, StallM, bus_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit in the memory stage of the pipelined RV32I core.
- Consumes the M-stage address (ALUResultM), store data (WriteDataM), funct3 and memory-control signals.
- Drives a request/grant data-memory bus and returns extended load data (RD_data) to the writeback path.
- Stalls the pipeline while a bus transaction is outstanding; flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum cycles spent in REQ plus WAIT_R before the access is abandoned. Must be ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  asynchronous, active-low reset
- MemReadM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- funct3M  in  3  access size/sign (RV32I load/store encoding)
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, unaligned in the low bits
- RD_data  out  32  extended load result; registered
- StallM  out  1  holds the F/D/E/M stages
- ErrM  out  1  one-cycle pulse on misaligned, illegal or timed-out access
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address (bits [1:0] = 0)
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:

Reset (clr low, asynchronous, any state)
- State goes to IDLE; timeout counter clears.
- All outputs go to 0.
- Reset mid-transaction abandons the access; bus_req drops immediately.

State machine: IDLE, REQ, WAIT_R, DONE.

Access classification in IDLE
- access = MemReadM | MemWriteM.
- Illegal if:
  - both MemReadM and MemWriteM are high,
  - a load uses funct3 011, 110 or 111,
  - a store uses funct3 other than 000, 001 or 010.
- Misaligned if:
  - a halfword access has addr[0] = 1,
  - a word access has addr[1:0] ≠ 0.
- Illegal or misaligned: ErrM pulses for 1 cycle, no bus activity, StallM stays 0, RD_data is loaded with 0, state stays IDLE.

Valid access in IDLE
- StallM = 1 combinationally in the same cycle.
- Next edge: state goes to REQ, and bus_req, bus_we, bus_addr = {addr[31:2], 2'b00}, bus_be and bus_wdata are registered.

Store lanes
- SB: be = 1 << addr[1:0]; wdata = byte replicated ×4.
- SH: be = 0011 if addr[1] = 0, else 1100; wdata = halfword replicated ×2.
- SW: be = 1111; wdata = WriteDataM.

Loads
- bus_be = 1111 and bus_we = 0 for every load size.

REQ
- bus_* outputs are held stable until bus_gnt.
- On bus_gnt, bus_req drops next edge:
  - store: go to DONE,
  - load: go to WAIT_R.

WAIT_R
- bus_rvalid is sampled only in WAIT_R, so the earliest accepted rvalid is the cycle after gnt.
- On rvalid, RD_data is loaded with the extracted/extended value and state goes to DONE.

Load extraction
- LB/LBU: byte at addr[1:0], sign- or zero-extended.
- LH/LHU: half at addr[1], sign- or zero-extended.
- LW: whole word.

DONE
- StallM = 0, so the pipeline advances this cycle; RD_data is valid.
- Next edge unconditionally goes to IDLE; inputs are ignored in DONE so the same instruction is never re-issued.
- A store leaves RD_data unchanged.

Stall
- StallM = 1 in REQ and WAIT_R, and in IDLE with a valid access.

Timeout
- Counter resets on entry to REQ and increments each cycle in REQ or WAIT_R.
- Reaching TIMEOUT: ErrM pulses, bus_req drops, RD_data is loaded with 0, state goes to DONE.
- bus_rvalid or bus_gnt arriving in IDLE or DONE is ignored.

Latency
- Store with gnt in the first REQ cycle: 3 cycles (IDLE-stall, REQ, DONE).
- Load with gnt and rvalid back-to-back: 4 cycles.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt 2 cycles after req → bus_addr 0x100, be 1111, wdata 0xDEADBEEF held stable across REQ; StallM high 3 cycles then low 1 cycle (DONE); ErrM never set.
- SB addr 0x103, data 0x000000A5 → be 1000, wdata 0xA5A5A5A5; LB addr 0x103 with rdata 0x80123456 → RD_data 0xFFFFFF80 in DONE.
- LHU addr 0x102 with rdata 0xBEEF1234 → RD_data 0x0000BEEF; LH at the same address → 0xFFFFBEEF.
- Faults:
  - SH addr 0x101 → ErrM 1-cycle pulse, bus_req never asserted, StallM stays 0.
  - Load with funct3 011 → same response.
  - MemReadM = MemWriteM = 1 → same response.
- LW with gnt but no rvalid, TIMEOUT = 16 → ErrM pulses 16 cycles after REQ entry; RD_data 0; pipeline released; a late rvalid in IDLE has no effect.
- clr low during WAIT_R → all outputs 0 immediately; after release, a new LW at 0x200 completes normally with the correct data.
